nvr_fetch_ctrl: RTL and testbench

Synthesizable read sequencer for the NVR_TOP instruction memory. It moves the NVR read protocol into RTL: power-on POR pulse, address setup, CE strobe, then a RDY wait. It sits between the Controller's PC_Addr/instruction ports and the NVR macro, and returns each fetched word through a req/ack handshake.

---
 rtl/nvr_fetch_ctrl_if.sv | 16 +
 rtl/nvr_fetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_nvr_fetch_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/nvr_fetch_ctrl_if.sv
// Fetch handshake between the Controller (master) and nvr_fetch_ctrl (slave).
// The requester holds req high until ack and keeps addr stable while busy.
interface nvr_fetch_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;

  modport master (output req, addr, input ack, rdata, err, busy);
  modport slave  (input req, addr, output ack, rdata, err, busy);
endinterface

// File: rtl/nvr_fetch_ctrl.sv
// Read sequencer for the NVR_TOP instruction memory: POR pulse after reset,
// address setup, CE strobe, RDY wait, then a one-cycle ack with the fetched
// word (or err on timeout). Every output is registered.
// Optional feature: define NVR_FETCH_CACHE_EN to add a one-entry tag so a
// repeated request for the last good address is answered without strobing
// the NVR. The tag address is nvr_a itself, which always holds the last
// fetched address; only the valid bit is extra state.
module nvr_fetch_ctrl #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int POR_CYCLES   = 2,
  parameter int SETUP_CYCLES = 2,
  parameter int CE_CYCLES    = 1,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  nvr_fetch_ctrl_if.slave   fetch,
  output logic [ADDR_W-1:0] nvr_a,
  output logic              nvr_ce,
  output logic              nvr_por,
  input  logic [DATA_W-1:0] nvr_dout,
  input  logic              nvr_rdy
);

  // One counter serves every timed state; it only has to reach count-1.
  localparam int MAX_A   = (POR_CYCLES > SETUP_CYCLES) ? POR_CYCLES : SETUP_CYCLES;
  localparam int MAX_B   = (CE_CYCLES > TIMEOUT) ? CE_CYCLES : TIMEOUT;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CE_LAST    = CNT_W'(CE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    POR_HI, POR_WAIT, IDLE, SETUP, STROBE, WAIT_RDY, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] nvr_a_d;
  logic              nvr_ce_d, nvr_por_d;

`ifdef NVR_FETCH_CACHE_EN
  logic tag_valid_q, tag_valid_d;
  logic hit;
  assign hit = tag_valid_q && (fetch.addr == nvr_a);
`endif

  // Next state, counter and next values of every registered output.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    nvr_a_d   = nvr_a;
    nvr_ce_d  = 1'b0;
    nvr_por_d = 1'b0;
`ifdef NVR_FETCH_CACHE_EN
    tag_valid_d = tag_valid_q;
`endif
    unique case (state_q)
      POR_HI: begin
        nvr_por_d = 1'b1;
        if (cnt_q == POR_LAST) state_d = POR_WAIT;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      POR_WAIT: begin
        if (nvr_rdy) state_d = IDLE;
      end
      IDLE: begin
        if (fetch.req) begin
          nvr_a_d = fetch.addr;
          err_d   = 1'b0;
`ifdef NVR_FETCH_CACHE_EN
          state_d = hit ? DONE : SETUP;
`else
          state_d = SETUP;
`endif
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d  = STROBE;
          nvr_ce_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == CE_LAST) begin
          state_d = WAIT_RDY;
        end else begin
          nvr_ce_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RDY: begin
        // Data capture takes priority over a timeout expiring on the same edge.
        if (nvr_rdy) begin
          rdata_d = nvr_dout;
          state_d = DONE;
`ifdef NVR_FETCH_CACHE_EN
          tag_valid_d = 1'b1;
`endif
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
`ifdef NVR_FETCH_CACHE_EN
          tag_valid_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = POR_HI;
    endcase
    // The counter restarts from zero on every state entry.
    if (state_d != state_q) cnt_d = '0;
    ack_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register update from pre-edge values.
    if (reset) begin
      state_q <= POR_HI;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
      rdata_q <= '0;
      nvr_a   <= '0;
      nvr_ce  <= 1'b0;
      nvr_por <= 1'b0;
`ifdef NVR_FETCH_CACHE_EN
      tag_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      nvr_a   <= nvr_a_d;
      nvr_ce  <= nvr_ce_d;
      nvr_por <= nvr_por_d;
`ifdef NVR_FETCH_CACHE_EN
      tag_valid_q <= tag_valid_d;
`endif
    end
  end

  assign fetch.ack   = ack_q;
  assign fetch.err   = err_q;
  assign fetch.busy  = busy_q;
  assign fetch.rdata = rdata_q;

endmodule

// File: tb/tb_nvr_fetch_ctrl.sv
// Directed bench for nvr_fetch_ctrl: an NVR word model drives nvr_dout from
// nvr_a, expected acks are queued when a request is driven and checked when
// ack appears. Outputs are sampled on the falling edge.
module tb_nvr_fetch_ctrl;
  localparam int ADDR_W       = 7;
  localparam int DATA_W       = 32;
  localparam int POR_CYCLES   = 2;
  localparam int SETUP_CYCLES = 2;
  localparam int CE_CYCLES    = 1;
  localparam int TIMEOUT      = 64;
  localparam int LAT    = SETUP_CYCLES + CE_CYCLES + 2;
  localparam int TO_LAT = SETUP_CYCLES + CE_CYCLES + TIMEOUT + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] nvr_a;
  logic              nvr_ce, nvr_por, nvr_rdy;
  logic [DATA_W-1:0] nvr_dout;

  always #5 clk = ~clk;

  nvr_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fetch ();

  nvr_fetch_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .POR_CYCLES(POR_CYCLES),
    .SETUP_CYCLES(SETUP_CYCLES), .CE_CYCLES(CE_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .fetch(fetch),
    .nvr_a(nvr_a), .nvr_ce(nvr_ce), .nvr_por(nvr_por),
    .nvr_dout(nvr_dout), .nvr_rdy(nvr_rdy)
  );

  // NVR array model: a fixed word for address 5, a pattern elsewhere.
  function automatic logic [DATA_W-1:0] model(input logic [ADDR_W-1:0] a);
    if (a == 7'h05) return 32'h00500093;
    return {1'b1, a, 8'h3C, 1'b0, a, 8'hA5};
  endfunction

  assign nvr_dout = model(nvr_a);

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
    int unsigned       due;
    string             tag;
  } exp_t;

  exp_t              sb[$];
  int                total = 0;
  int                bad   = 0;
  logic [DATA_W-1:0] last_rdata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive a request and queue what its ack must carry and when.
  task automatic start_fetch(input logic [ADDR_W-1:0] a, input logic e,
                             input int lat, input string tag);
    exp_t x;
    x.data = e ? last_rdata : model(a);
    x.err  = e;
    x.due  = cyc + lat;
    x.tag  = tag;
    last_rdata  = x.data;
    fetch.req   = 1'b1;
    fetch.addr  = a;
    sb.push_back(x);
  endtask

  // Wait (bounded) for ack, compare against the queue head, confirm the pulse
  // is one cycle wide and the block is idle afterwards.
  task automatic wait_ack(input int budget, input logic drop_req);
    exp_t x;
    int   n = 0;
    while (fetch.ack !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (fetch.ack !== 1'b1) begin
      check("ack_seen", fetch.ack, 1);
      if (sb.size() > 0) sb.delete(0);
      fetch.req = 1'b0;
    end else if (sb.size() == 0) begin
      check("unexpected_ack", fetch.ack, 0);
    end else begin
      x = sb.pop_front();
      check({x.tag, "_rdata"}, fetch.rdata, x.data);
      check({x.tag, "_err"}, fetch.err, x.err);
      check({x.tag, "_cycle"}, cyc, x.due);
      if (drop_req) fetch.req = 1'b0;
      step();
      check({x.tag, "_ack_width"}, fetch.ack, 0);
      check({x.tag, "_idle"}, fetch.busy, 0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    fetch.req  = 1'b0;
    fetch.addr = '0;
    nvr_rdy    = 1'b0;

    // Power-up: two reset cycles, nvr_rdy raised at cycle 10.
    step();
    step();
    check("rst_ack", fetch.ack, 0);
    check("rst_err", fetch.err, 0);
    check("rst_rdata", fetch.rdata, 0);
    check("rst_nvr_a", nvr_a, 0);
    check("rst_ce", nvr_ce, 0);
    check("rst_por", nvr_por, 0);
    check("rst_busy", fetch.busy, 1);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("pwr_por_%0d", k), nvr_por, (k <= POR_CYCLES) ? 1 : 0);
      check($sformatf("pwr_ce_%0d", k), nvr_ce, 0);
      check($sformatf("pwr_busy_%0d", k), fetch.busy, (k <= 10) ? 1 : 0);
      if (k == 10) nvr_rdy = 1'b1;
    end

    // Single fetch of address 5 with nvr_rdy already high.
    start_fetch(7'h05, 1'b0, LAT, "single");
    step();
    check("single_nvr_a", nvr_a, 7'h05);
    check("single_busy", fetch.busy, 1);
    step();
    check("single_ce_c2", nvr_ce, 0);
    step();
    check("single_ce_c3", nvr_ce, 1);
    step();
    check("single_ce_c4", nvr_ce, 0);
    wait_ack(10, 1'b1);

    // Back-to-back: req held high across addresses 0, 1, 2.
    for (int a = 0; a < 3; a++) begin
      start_fetch(ADDR_W'(a), 1'b0, LAT, $sformatf("b2b%0d", a));
      wait_ack(10, a == 2);
    end

    // RDY glitch during STROBE is ignored; capture on a later RDY.
    nvr_rdy = 1'b0;
    start_fetch(7'h11, 1'b0, 8, "glitch");
    step();
    step();
    step();
    check("glitch_ce", nvr_ce, 1);
    nvr_rdy = 1'b1;
    step();
    nvr_rdy = 1'b0;
    step();
    step();
    step();
    check("glitch_no_ack", fetch.ack, 0);
    nvr_rdy = 1'b1;
    wait_ack(5, 1'b1);

    // Timeout: nvr_rdy held low; rdata keeps the previous word.
    nvr_rdy = 1'b0;
    start_fetch(7'h09, 1'b1, TO_LAT, "timeout");
    wait_ack(TO_LAT + 5, 1'b1);
    check("timeout_err_held", fetch.err, 1);
    nvr_rdy = 1'b1;
    start_fetch(7'h0A, 1'b0, LAT, "recover");
    step();
    check("recover_err_clr", fetch.err, 0);
    wait_ack(10, 1'b1);

    // RDY on the last timeout cycle: capture wins, err stays 0.
    nvr_rdy = 1'b0;
    start_fetch(7'h0B, 1'b0, TO_LAT, "tie");
    for (int i = 0; i < TO_LAT - 1; i++) step();
    nvr_rdy = 1'b1;
    wait_ack(5, 1'b1);

    // Reset during STROBE: CE drops at once, no ack, POR restarts.
    fetch.req  = 1'b1;
    fetch.addr = 7'h0C;
    step();
    step();
    step();
    check("midrst_ce_before", nvr_ce, 1);
    reset     = 1'b1;
    fetch.req = 1'b0;
    step();
    check("midrst_ce", nvr_ce, 0);
    check("midrst_ack", fetch.ack, 0);
    check("midrst_busy", fetch.busy, 1);
    check("midrst_rdata", fetch.rdata, 0);
    last_rdata = '0;
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("midrst_por_%0d", k), nvr_por, (k <= POR_CYCLES) ? 1 : 0);
      check($sformatf("midrst_noack_%0d", k), fetch.ack, 0);
      check($sformatf("midrst_busy_%0d", k), fetch.busy, (k <= POR_CYCLES) ? 1 : 0);
    end

`ifdef NVR_FETCH_CACHE_EN
    // Cache: second fetch of address 3 answers one cycle after req, no strobe.
    start_fetch(7'h03, 1'b0, LAT, "cache_miss");
    wait_ack(10, 1'b1);
    start_fetch(7'h03, 1'b0, 1, "cache_hit");
    step();
    check("cache_hit_ce", nvr_ce, 0);
    wait_ack(3, 1'b1);
`else
    // No cache: a repeated address still runs the full sequence.
    start_fetch(7'h0D, 1'b0, LAT, "repeat1");
    wait_ack(10, 1'b1);
    start_fetch(7'h0D, 1'b0, LAT, "repeat2");
    wait_ack(10, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
